// File: rtl/rnn_cell_seq.sv
// Time-multiplexed recurrent cell: x' = tanh_lut(W*x) + B*u, y = C*x'.
// One shared MAC walks W, B and C row-major; hidden state restarts every SEQ_LEN samples.
module rnn_cell_seq #(
  parameter int unsigned N_IN    = 3,
  parameter int unsigned N_HID   = 4,
  parameter int unsigned N_OUT   = 2,
  parameter int unsigned W       = 18,
  parameter int unsigned FRAC    = 12,
  parameter int unsigned LUT_AW  = 7,
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned ADDR_W  = 8,
  localparam int unsigned STEP_W = (SEQ_LEN == 0) ? 1 : $clog2(SEQ_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_IN*W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*W-1:0]    out_data,
  input  logic                  wt_we,
  input  logic [1:0]            wt_sel,
  input  logic [ADDR_W-1:0]     wt_addr,
  input  logic [W-1:0]          wt_data,
  output logic                  wt_err,
  output logic [STEP_W-1:0]     step
);

  localparam int unsigned AW     = W + 4;
  localparam int unsigned PW     = 2 * W;
  localparam int unsigned W_SZ   = N_HID * N_HID;
  localparam int unsigned B_SZ   = N_HID * N_IN;
  localparam int unsigned C_SZ   = N_OUT * N_HID;
  localparam int unsigned L_SZ   = 1 << LUT_AW;
  localparam int unsigned W_AW   = (W_SZ > 1) ? $clog2(W_SZ) : 1;
  localparam int unsigned B_AW   = (B_SZ > 1) ? $clog2(B_SZ) : 1;
  localparam int unsigned C_AW   = (C_SZ > 1) ? $clog2(C_SZ) : 1;
  localparam int unsigned MAXN_A = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned MAXN   = (MAXN_A > N_OUT) ? MAXN_A : N_OUT;
  localparam int unsigned CNT_W  = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam int unsigned MAXM_A = (W_SZ > B_SZ) ? W_SZ : B_SZ;
  localparam int unsigned MAXM   = (MAXM_A > C_SZ) ? MAXM_A : C_SZ;
  localparam int unsigned IDX_W  = (MAXM > 1) ? $clog2(MAXM) : 1;
  localparam int unsigned HID_IW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int unsigned IN_IW  = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MAC_W  = 3'd1;
  localparam logic [2:0] S_MAC_B  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_MAC_C  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Clamp a widened accumulator to the signed W-bit range.
  function automatic logic signed [W-1:0] sat(input logic signed [AW-1:0] v);
    if ((v[AW-1:W-1] == '0) || (v[AW-1:W-1] == '1)) return v[W-1:0];
    return v[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  // Coefficient and LUT storage, written only from IDLE, never reset
  logic signed [W-1:0] w_mem   [W_SZ];
  logic signed [W-1:0] b_mem   [B_SZ];
  logic signed [W-1:0] c_mem   [C_SZ];
  logic signed [W-1:0] lut_mem [L_SZ];

  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [N_OUT*W-1:0]      out_data_q, out_data_d;
  logic                    wt_err_q, wt_err_d;
  logic signed [W-1:0]     x_q [N_HID];
  logic signed [W-1:0]     x_d [N_HID];
  logic signed [W-1:0]     u_q [N_IN];
  logic signed [W-1:0]     u_d [N_IN];
  logic [LUT_AW-1:0]       p_q [N_HID];
  logic [LUT_AW-1:0]       p_d [N_HID];
  logic signed [W-1:0]     bu_q [N_HID];
  logic signed [W-1:0]     bu_d [N_HID];

  logic                    accept_c, in_range_c, wr_ok_c;
  logic                    col_last_c, row_last_c;
  logic [CNT_W-1:0]        col_max_c, row_max_c;
  logic signed [W-1:0]     mac_a_c, mac_b_c, sat_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [AW-1:0]    acc_base_c, sum_c;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign wt_err    = wt_err_q;
  assign step      = step_q;

  // Next-state, datapath and write-qualification logic
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    step_d      = step_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    x_d         = x_q;
    u_d         = u_q;
    p_d         = p_q;
    bu_d        = bu_q;
    mac_a_c     = '0;
    mac_b_c     = '0;
    col_max_c   = '0;
    row_max_c   = '0;
    in_range_c  = 1'b0;

    accept_c = (state_q == S_IDLE) && in_valid && in_ready_q;
    case (wt_sel)
      2'd0:    in_range_c = 32'(wt_addr) < W_SZ;
      2'd1:    in_range_c = 32'(wt_addr) < B_SZ;
      2'd2:    in_range_c = 32'(wt_addr) < C_SZ;
      default: in_range_c = 32'(wt_addr) < L_SZ;
    endcase
    // The FSM leaves IDLE on an accept edge, so a write in that cycle is dropped
    wr_ok_c  = wt_we && (state_q == S_IDLE) && !accept_c && in_range_c;
    wt_err_d = wt_we && !wr_ok_c;

    case (state_q)
      S_MAC_W: begin
        mac_a_c   = w_mem[W_AW'(idx_q)];
        mac_b_c   = x_q[HID_IW'(col_q)];
        col_max_c = CNT_W'(N_HID - 1);
        row_max_c = CNT_W'(N_HID - 1);
      end
      S_MAC_B: begin
        mac_a_c   = b_mem[B_AW'(idx_q)];
        mac_b_c   = u_q[IN_IW'(col_q)];
        col_max_c = CNT_W'(N_IN - 1);
        row_max_c = CNT_W'(N_HID - 1);
      end
      S_MAC_C: begin
        mac_a_c   = c_mem[C_AW'(idx_q)];
        mac_b_c   = x_q[HID_IW'(col_q)];
        col_max_c = CNT_W'(N_HID - 1);
        row_max_c = CNT_W'(N_OUT - 1);
      end
      default: ;
    endcase

    if (col_q == '0) acc_base_c = '0;
    else             acc_base_c = acc_q;
    prod_c     = PW'(mac_a_c) * PW'(mac_b_c);
    sum_c      = acc_base_c + AW'(prod_c >>> FRAC);
    sat_c      = sat(sum_c);
    col_last_c = (col_q == col_max_c);
    row_last_c = (row_q == row_max_c);

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          for (int k = 0; k < N_IN; k++) u_d[k] = in_data[k*W +: W];
          state_d = (step_q == '0) ? S_MAC_B : S_MAC_W;
          row_d   = '0;
          col_d   = '0;
          idx_d   = '0;
        end
      end
      S_MAC_W, S_MAC_B, S_MAC_C: begin
        acc_d = sum_c;
        idx_d = idx_q + IDX_W'(1);
        col_d = col_q + CNT_W'(1);
        if (col_last_c) begin
          col_d = '0;
          row_d = row_q + CNT_W'(1);
          // Only the LUT address of the pre-activation is ever needed
          case (state_q)
            S_MAC_W: p_d[HID_IW'(row_q)]  = sat_c[W-1 -: LUT_AW];
            S_MAC_B: bu_d[HID_IW'(row_q)] = sat_c;
            default: out_data_d[W*32'(row_q) +: W] = sat_c;
          endcase
          if (row_last_c) begin
            row_d = '0;
            idx_d = '0;
            case (state_q)
              S_MAC_W: state_d = S_MAC_B;
              S_MAC_B: state_d = S_COMMIT;
              default: state_d = S_DONE;
            endcase
          end
        end
      end
      S_COMMIT: begin
        for (int i = 0; i < N_HID; i++) begin
          x_d[i] = sat(AW'(bu_q[i]) +
                       ((step_q == '0) ? AW'(0) : AW'(lut_mem[p_q[i]])));
        end
        // SEQ_LEN of zero means the step counter saturates instead of wrapping
        if (SEQ_LEN == 0)
          step_d = (&step_q) ? step_q : step_q + STEP_W'(1);
        else
          step_d = (step_q == STEP_W'(SEQ_LEN - 1)) ? '0 : step_q + STEP_W'(1);
        state_d = S_MAC_C;
      end
      S_DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wt_err_q    <= 1'b0;
      for (int i = 0; i < N_HID; i++) begin
        x_q[i]  <= '0;
        p_q[i]  <= '0;
        bu_q[i] <= '0;
      end
      for (int k = 0; k < N_IN; k++) u_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wt_err_q    <= wt_err_d;
      x_q         <= x_d;
      p_q         <= p_d;
      bu_q        <= bu_d;
      u_q         <= u_d;
    end
  end

  // Coefficient / LUT write port
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      case (wt_sel)
        2'd0:    w_mem[W_AW'(wt_addr)]     <= wt_data;
        2'd1:    b_mem[B_AW'(wt_addr)]     <= wt_data;
        2'd2:    c_mem[C_AW'(wt_addr)]     <= wt_data;
        default: lut_mem[LUT_AW'(wt_addr)] <= wt_data;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_cell_seq.sv
// Directed bench for rnn_cell_seq at default sizes (3 in, 4 hidden, 2 out, Q6.12).
module tb_rnn_cell_seq;
  localparam int W = 18;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3*W-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] out_data;
  logic          wt_we = 1'b0;
  logic [1:0]    wt_sel = '0;
  logic [7:0]    wt_addr = '0;
  logic [W-1:0]  wt_data = '0;
  logic          wt_err;
  logic [2:0]    step;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rnn_cell_seq dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wt_we(wt_we), .wt_sel(wt_sel), .wt_addr(wt_addr), .wt_data(wt_data),
    .wt_err(wt_err), .step(step)
  );

  task automatic wr(input logic [1:0] sel, input int addr, input int data);
    @(negedge clk);
    wt_we = 1'b1; wt_sel = sel; wt_addr = 8'(addr); wt_data = 18'(data);
    @(posedge clk); #1;
    wt_we = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drive one sample, wait for the result, complete the output handshake
  task automatic send(input int u0, input int u1, input int u2,
                      output int lat, output int st,
                      output logic [W-1:0] y0, output logic [W-1:0] y1);
    int n;
    @(negedge clk);
    in_data  = {18'(u2), 18'(u1), 18'(u0)};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    st = int'(step);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    y0 = out_data[W-1:0];
    y1 = out_data[2*W-1:W];
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic load_identity;
    for (int a = 0; a < 16; a++) wr(2'd0, a, 0);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) wr(2'd1, i*3 + k, (i == k) ? 4096 : 0);
    for (int o = 0; o < 2; o++)
      for (int i = 0; i < 4; i++)
        wr(2'd2, o*4 + i, (o == 0) ? 4096 : ((i == 0) ? 8192 : 0));
    for (int a = 0; a < 128; a++) wr(2'd3, a, a * 64);
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_vec++; if (out_data !== 36'd0) begin n_miss++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    n_vec++; if (wt_err !== 1'b0) begin n_miss++; $display("FAIL reset_wt_err got=%b want=0", wt_err); end
    n_vec++; if (step !== 3'd0) begin n_miss++; $display("FAIL reset_step got=%0d want=0", step); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_identity;
    int lat, st; logic [W-1:0] y0, y1;
    do_reset();
    send(4096, 2048, -1024, lat, st, y0, y1);
    n_vec++; if (lat != 22) begin n_miss++; $display("FAIL ident_latency got=%0d want=22", lat); end
    n_vec++; if (st != 0) begin n_miss++; $display("FAIL ident_step got=%0d want=0", st); end
    n_vec++; if (y0 !== 18'd5120) begin n_miss++; $display("FAIL ident_y0 got=%0d want=5120", $signed(y0)); end
    n_vec++; if (y1 !== 18'd8192) begin n_miss++; $display("FAIL ident_y1 got=%0d want=8192", $signed(y1)); end
  endtask

  task automatic test_saturation;
    int lat, st; logic [W-1:0] y0, y1;
    do_reset();
    wr(2'd1, 0, 65536);
    send(32768, 0, 0, lat, st, y0, y1);
    n_vec++; if (y0 !== 18'h1FFFF) begin n_miss++; $display("FAIL sat_pos_y0 got=%0d want=131071", $signed(y0)); end
    n_vec++; if (y1 !== 18'h1FFFF) begin n_miss++; $display("FAIL sat_pos_y1 got=%0d want=131071", $signed(y1)); end
    do_reset();
    send(-32768, 0, 0, lat, st, y0, y1);
    n_vec++; if (y0 !== 18'h20000) begin n_miss++; $display("FAIL sat_neg_y0 got=%0d want=-131072", $signed(y0)); end
    n_vec++; if (y1 !== 18'h20000) begin n_miss++; $display("FAIL sat_neg_y1 got=%0d want=-131072", $signed(y1)); end
    wr(2'd1, 0, 4096);
  endtask

  task automatic test_recurrence;
    int lat, st; logic [W-1:0] y0, y1;
    int exp_lat [5] = '{22, 38, 38, 38, 22};
    int exp_y0  [5] = '{5120, 13568, 13824, 13824, 5120};
    int exp_y1  [5] = '{8192, 8832, 9344, 9344, 8192};
    wr(2'd0, 0, 8192);
    wr(2'd0, 1, 4096);
    wr(2'd0, 6, 4096);
    do_reset();
    for (int s = 0; s < 5; s++) begin
      send(4096, 2048, -1024, lat, st, y0, y1);
      n_vec++; if (lat != exp_lat[s]) begin n_miss++; $display("FAIL rec_latency[%0d] got=%0d want=%0d", s, lat, exp_lat[s]); end
      n_vec++; if (st != (s % 4)) begin n_miss++; $display("FAIL rec_step[%0d] got=%0d want=%0d", s, st, s % 4); end
      n_vec++; if (y0 !== 18'(exp_y0[s])) begin n_miss++; $display("FAIL rec_y0[%0d] got=%0d want=%0d", s, $signed(y0), exp_y0[s]); end
      n_vec++; if (y1 !== 18'(exp_y1[s])) begin n_miss++; $display("FAIL rec_y1[%0d] got=%0d want=%0d", s, $signed(y1), exp_y1[s]); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    do_reset();
    @(negedge clk);
    in_data = {18'(-1024), 18'(2048), 18'(4096)};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    n_vec++; if (lat != 22) begin n_miss++; $display("FAIL bp_latency got=%0d want=22", lat); end
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_vec++; if (out_valid !== 1'b1) begin n_miss++; $display("FAIL bp_out_valid[%0d] got=%b want=1", c, out_valid); end
      n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, in_ready); end
      n_vec++; if (out_data !== {18'd8192, 18'd5120}) begin n_miss++; $display("FAIL bp_out_data[%0d] got=%h want=%h", c, out_data, {18'd8192, 18'd5120}); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL bp_after_out_valid got=%b want=0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL bp_after_in_ready got=%b want=1", in_ready); end
    n_vec++; if (step !== 3'd1) begin n_miss++; $display("FAIL bp_after_step got=%0d want=1", step); end
  endtask

  task automatic test_write_rules;
    int lat, st; logic [W-1:0] y0, y1;
    logic e1, e2, e3;
    do_reset();
    fork
      send(4096, 2048, -1024, lat, st, y0, y1);
      begin
        @(negedge clk);
        repeat (3) @(negedge clk);
        wt_we = 1'b1; wt_sel = 2'd1; wt_addr = 8'd0; wt_data = 18'd999;
        @(posedge clk); #1;
        wt_we = 1'b0;
        e1 = wt_err;
        @(posedge clk); #1;
        e2 = wt_err;
      end
    join
    n_vec++; if (e1 !== 1'b1) begin n_miss++; $display("FAIL wr_busy_err got=%b want=1", e1); end
    n_vec++; if (e2 !== 1'b0) begin n_miss++; $display("FAIL wr_busy_err_pulse got=%b want=0", e2); end
    do_reset();
    fork
      send(4096, 2048, -1024, lat, st, y0, y1);
      begin
        @(negedge clk);
        wt_we = 1'b1; wt_sel = 2'd2; wt_addr = 8'd0; wt_data = 18'd0;
        @(posedge clk); #1;
        wt_we = 1'b0;
        e3 = wt_err;
      end
    join
    n_vec++; if (e3 !== 1'b1) begin n_miss++; $display("FAIL wr_accept_err got=%b want=1", e3); end
    wr(2'd0, 16, 1234);
    n_vec++; if (wt_err !== 1'b1) begin n_miss++; $display("FAIL wr_range_w_err got=%b want=1", wt_err); end
    wr(2'd3, 128, 77);
    n_vec++; if (wt_err !== 1'b1) begin n_miss++; $display("FAIL wr_range_lut_err got=%b want=1", wt_err); end
    wr(2'd1, 0, 4096);
    n_vec++; if (wt_err !== 1'b0) begin n_miss++; $display("FAIL wr_valid_err got=%b want=0", wt_err); end
    do_reset();
    send(4096, 2048, -1024, lat, st, y0, y1);
    n_vec++; if (y0 !== 18'd5120) begin n_miss++; $display("FAIL wr_repeat_y0 got=%0d want=5120", $signed(y0)); end
    n_vec++; if (y1 !== 18'd8192) begin n_miss++; $display("FAIL wr_repeat_y1 got=%0d want=8192", $signed(y1)); end
  endtask

  task automatic test_reset_midop;
    int lat, st; logic [W-1:0] y0, y1;
    do_reset();
    send(4096, 2048, -1024, lat, st, y0, y1);
    @(negedge clk);
    in_data = {18'(-1024), 18'(2048), 18'(4096)};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (out_valid !== 1'b0) begin n_miss++; $display("FAIL midop_out_valid got=%b want=0", out_valid); end
    n_vec++; if (step !== 3'd0) begin n_miss++; $display("FAIL midop_step got=%0d want=0", step); end
    n_vec++; if (in_ready !== 1'b0) begin n_miss++; $display("FAIL midop_in_ready got=%b want=0", in_ready); end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (in_ready !== 1'b1) begin n_miss++; $display("FAIL midop_release_in_ready got=%b want=1", in_ready); end
    n_vec++; if (out_data !== 36'd0) begin n_miss++; $display("FAIL midop_out_data got=%h want=0", out_data); end
    send(4096, 2048, -1024, lat, st, y0, y1);
    n_vec++; if (lat != 22) begin n_miss++; $display("FAIL midop_next_latency got=%0d want=22", lat); end
    n_vec++; if (st != 0) begin n_miss++; $display("FAIL midop_next_step got=%0d want=0", st); end
    n_vec++; if (y0 !== 18'd5120) begin n_miss++; $display("FAIL midop_next_y0 got=%0d want=5120", $signed(y0)); end
    n_vec++; if (y1 !== 18'd8192) begin n_miss++; $display("FAIL midop_next_y1 got=%0d want=8192", $signed(y1)); end
  endtask

  initial begin
    test_reset();
    load_identity();
    test_identity();
    test_saturation();
    test_recurrence();
    test_backpressure();
    test_write_rules();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rnn_cell_seq.md
# rnn_cell_seq

Parametrised, time-multiplexed recurrent cell. Per accepted input sample it computes the new hidden state x' = tanh_lut(W·x) + B·u and the output y = C·x'. It generalises the fixed 3-in/4-hidden/2-out datapath to arbitrary sizes. It uses a single shared MAC, a valid/ready handshake on both sides, run-time loadable coefficients and LUT, saturating arithmetic, and a configurable sequence length after which hidden state restarts. It sits between the sample front-end and the output consumer in the NN datapath.

## Interface
- N_IN, 3: input channels (u)
- N_HID, 4: hidden neurons (x)
- N_OUT, 2: output channels (y)
- W, 18: data width, signed two's complement
- FRAC, 12: fractional bits (default Q6.12)
- LUT_AW, 7: tanh LUT address bits (2^LUT_AW entries)
- SEQ_LEN, 4: samples per sequence; hidden state restarts when the step counter wraps; 0 = never wrap
- ADDR_W, 8: coefficient write address width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  cell can accept a sample
- in_data  in  N_IN*W  u[k] at bits [k*W +: W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  N_OUT*W  y[o] at bits [o*W +: W]
- wt_we  in  1  coefficient write strobe
- wt_sel  in  2  write target: 0=W[i*N_HID+j], 1=B[i*N_IN+k], 2=C[o*N_HID+i], 3=LUT[a]
- wt_addr  in  ADDR_W  element index
- wt_data  in  W  element value
- wt_err  out  1  one-cycle pulse: write dropped (busy or address out of range)
- step  out  $clog2(SEQ_LEN+1)  current step index within the sequence

## Operation
- FSM states: IDLE, MAC_W, MAC_B, COMMIT, MAC_C, DONE.
- IDLE: in_ready=1. An accept happens when in_valid&&in_ready. On accept, latch u and go to MAC_W, or to MAC_B if step==0.
- MAC_W: one product per cycle, row-major over i,j, W[i][j]*x[j]. At each row end, store the saturated pre-activation p[i].
- MAC_B: row-major over i,k, B[i][k]*u[k]. At each row end, store the saturated bu[i].
- COMMIT, one cycle: x[i] <= sat(bu[i] + (step==0 ? 0 : LUT[p[i][W-1 -: LUT_AW]])). The LUT index is the top LUT_AW bits of p[i], interpreted as unsigned. Old x is used throughout MAC_W, because x updates only here. The step counter advances here and wraps to 0 after SEQ_LEN-1.
- MAC_C: row-major over o,i, C[o][i]*x[i] using the committed x. Store the saturated y[o].
- DONE: out_valid=1 and out_data holds y. On out_valid&&out_ready, go to IDLE.
- Products: full 2W-bit signed product, arithmetic-shifted right by FRAC (truncation toward −inf).
- Accumulation: W+4 bits, saturated to W bits [−2^(W-1), 2^(W-1)−1] at each row end and at COMMIT.
- Coefficient writes are accepted only in IDLE and only for in-range addresses. Any other write is dropped and pulses wt_err the next cycle.
- Memories (W, B, C, LUT) are not cleared by reset. Their contents are undefined until written.

## Timing
- Reset values: in_ready=0 during reset and 1 the cycle after; out_valid=0; out_data=0; wt_err=0; step=0; x=0; FSM=IDLE.
- Latency from the accept edge to out_valid high:
  - L = (step==0 ? 0 : N_HID²) + N_HID*N_IN + 1 + N_OUT*N_HID + 1.
  - Defaults: 22 cycles at step 0, 38 otherwise.
- in_ready=0 from the cycle after accept until the cycle after the out handshake. There is no sample overlap.
- out_data is stable while out_valid=1 and out_ready=0. Backpressure is unbounded.
- A coefficient write in the same cycle as an accept is dropped and flagged, because the FSM leaves IDLE on that edge.
- Reset asserted mid-computation aborts the computation. The cycle after deassertion all outputs are at reset values and x=0.

## Test plan
- Identity path: set W=0, B[i][i]=4096, C[0][*]=4096, C[1][0]=8192, other coefficients 0. Drive u=(4096,2048,−1024) at step 0. Required: after 22 cycles, out_valid=1, y0=5120, y1=8192.
- Saturation: B[0][0]=65536 (16.0), u0=32768 (8.0), C[0][0]=4096. Required: x0=131071 and y0=131071. With u0=−32768, both are −131072.
- Recurrence and sequence wrap: SEQ_LEN=4, LUT[a]=a*64, and a nonzero W. Feed 5 samples. Required: samples 2–4 have latency 38 and include the LUT term; sample 5 has latency 22 and equals the sample-1 result for equal u; step reads 0,1,2,3,0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Required: out_data is constant, in_ready=0, and a concurrent in_valid is not accepted.
- Write rules: issue wt_we during MAC_B and wt_we with wt_addr=N_HID² while wt_sel=0. Required: a wt_err pulse one cycle after each, and the memory is unchanged (repeat the identity test for an identical result).
- Reset mid-op: assert reset during MAC_C. Required: out_valid=0, x=0, and step=0. The next sample behaves as step 0 with latency 22.
